// File: rtl/lab2_bls_div_ctrl.sv
// Sequential restoring divider. It produces one quotient bit per clock, MSB
// first. Every trial subtraction goes through one chain of 4-bit
// borrow-lookahead subtractor nibbles, linked by their borrows.
module lab2_bls_div_ctrl #(
    parameter int N_NIB = 1,
    localparam int W = 4 * N_NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic         dz,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DZ,
        S_DONE
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [W-1:0]   q_reg;
    logic [W-1:0]   r_reg;
    logic [W-1:0]   dv_reg;
    logic [CW-1:0]  cnt_reg;
    logic [W-1:0]   quotient_reg;
    logic [W-1:0]   remainder_reg;
    logic           dz_reg;

    logic           accept;
    logic [W-1:0]   trial;
    logic [W-1:0]   diff;
    logic [N_NIB:0] borrow;
    logic           bout;
    logic           qbit;
    logic [W-1:0]   r_next;
    logic [W-1:0]   q_next;

    // The partial remainder shifts left and takes in the next dividend bit.
    assign trial     = {r_reg[W-2:0], q_reg[W-1]};
    assign borrow[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N_NIB; gi++) begin : g_nib
            logic [3:0] na;
            logic [3:0] nb;
            logic [3:0] ng;
            logic [3:0] np;
            logic [3:0] nc;
            logic       cin;

            assign na  = trial[4*gi +: 4];
            assign nb  = dv_reg[4*gi +: 4];
            assign cin = borrow[gi];

            // A bit generates a borrow when a=0 and b=1.
            // It passes the incoming borrow through when a==b.
            assign ng = ~na & nb;
            assign np = ~(na ^ nb);

            assign nc[0] = cin;
            assign nc[1] = ng[0] | (np[0] & cin);
            assign nc[2] = ng[1] | (np[1] & ng[0]) | (np[1] & np[0] & cin);
            assign nc[3] = ng[2] | (np[2] & ng[1]) | (np[2] & np[1] & ng[0])
                         | (np[2] & np[1] & np[0] & cin);
            assign borrow[gi+1] = ng[3] | (np[3] & ng[2]) | (np[3] & np[2] & ng[1])
                                | (np[3] & np[2] & np[1] & ng[0])
                                | (np[3] & np[2] & np[1] & np[0] & cin);

            assign diff[4*gi +: 4] = na ^ nb ^ nc;
        end
    endgenerate

    // When a 1 is shifted out of the remainder, the true trial value is
    // 2^W or more. That is still below 2*Dv, so the subtraction must succeed,
    // and the result taken mod 2^W is exact.
    assign bout   = borrow[N_NIB];
    assign qbit   = r_reg[W-1] | ~bout;
    assign r_next = qbit ? diff : trial;
    assign q_next = {q_reg[W-2:0], qbit};

    assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? S_DZ : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DZ: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = (divisor == '0) ? S_DZ : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers.
    // The result registers are loaded only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg         <= '0;
            r_reg         <= '0;
            dv_reg        <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
        end else if (accept) begin
            q_reg   <= dividend;
            dv_reg  <= divisor;
            r_reg   <= '0;
            cnt_reg <= CW'(W - 1);
            dz_reg  <= 1'b0;
        end else if (state_reg == S_RUN) begin
            r_reg   <= r_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                quotient_reg  <= q_next;
                remainder_reg <= r_next;
            end
        end else if (state_reg == S_DZ) begin
            quotient_reg  <= '1;
            remainder_reg <= q_reg;
            dz_reg        <= 1'b1;
        end
    end

    assign dz        = dz_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

endmodule

// File: tb/tb_lab2_bls_div_ctrl.sv
// Self-checking bench for lab2_bls_div_ctrl.
// It drives a 4-bit instance (N_NIB=1) and an 8-bit instance (N_NIB=2),
// and compares them against an arithmetic reference model (/ and %).
module tb_lab2_bls_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start1 = 1'b0;
    logic [3:0] dvd1 = '0;
    logic [3:0] dvs1 = '0;
    logic       busy1;
    logic       done1;
    logic       dz1;
    logic [3:0] quo1;
    logic [3:0] rem1;

    logic       start2 = 1'b0;
    logic [7:0] dvd2 = '0;
    logic [7:0] dvs2 = '0;
    logic       busy2;
    logic       done2;
    logic       dz2;
    logic [7:0] quo2;
    logic [7:0] rem2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lab2_bls_div_ctrl #(.N_NIB(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dividend(dvd1), .divisor(dvs1),
        .busy(busy1), .done(done1), .dz(dz1), .quotient(quo1), .remainder(rem1)
    );

    lab2_bls_div_ctrl #(.N_NIB(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dividend(dvd2), .divisor(dvs2),
        .busy(busy2), .done(done2), .dz(dz2), .quotient(quo2), .remainder(rem2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b);
        if (sel == 1) begin
            start1 = s; dvd1 = a[3:0]; dvs1 = b[3:0];
        end else begin
            start2 = s; dvd2 = a; dvs2 = b;
        end
    endtask

    task automatic sample(input int sel, output logic bsy, output logic dn, output logic z,
                          output logic [7:0] q, output logic [7:0] r);
        if (sel == 1) begin
            bsy = busy1; dn = done1; z = dz1; q = {4'd0, quo1}; r = {4'd0, rem1};
        end else begin
            bsy = busy2; dn = done2; z = dz2; q = quo2; r = rem2;
        end
    endtask

    // Wait a bounded number of cycles for done. Return the cycle count
    // from the accepting edge.
    task automatic wait_done(input int sel, output int lat);
        logic bsy, dn, z;
        logic [7:0] q, r;
        lat = 0;
        sample(sel, bsy, dn, z, q, r);
        while (!dn && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            sample(sel, bsy, dn, z, q, r);
        end
    endtask

    // One complete division, checked against the reference model.
    task automatic run_div(input int sel, input logic [7:0] a, input logic [7:0] b);
        int         w;
        int         lat;
        logic [7:0] mask;
        logic [7:0] eq, er;
        logic       bsy, dn, z;
        logic [7:0] q, r, oq, or_;
        w    = (sel == 1) ? 4 : 8;
        mask = (sel == 1) ? 8'h0F : 8'hFF;
        a    = a & mask;
        b    = b & mask;
        eq   = (b == 0) ? mask : 8'(a / b);
        er   = (b == 0) ? a    : 8'(a % b);
        @(negedge clk);
        sample(sel, bsy, dn, z, oq, or_);
        drive(sel, 1'b1, a, b);
        @(posedge clk); #1;
        drive(sel, 1'b0, 8'($urandom), 8'($urandom));
        sample(sel, bsy, dn, z, q, r);
        chk("accept_busy", 32'(bsy), 32'd1);
        chk("accept_dz_clear", 32'(z), 32'd0);
        chk("accept_q_held", 32'(q), 32'(oq));
        chk("accept_r_held", 32'(r), 32'(or_));
        wait_done(sel, lat);
        sample(sel, bsy, dn, z, q, r);
        $display("[TB] dut%0d %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", sel, a, b, q, r, z, lat);
        chk("latency", 32'(lat), (b == 0) ? 32'd1 : 32'(w));
        chk("quotient", 32'(q), 32'(eq));
        chk("remainder", 32'(r), 32'(er));
        chk("dz", 32'(z), (b == 0) ? 32'd1 : 32'd0);
        chk("done_busy", 32'(bsy), 32'd0);
        if (b != 0) begin
            chk("inv_sum", 32'(q) * 32'(b) + 32'(r), 32'(a));
            chk("inv_rlt", 32'(r < b), 32'd1);
        end
        @(posedge clk); #1;
        sample(sel, bsy, dn, z, q, r);
        chk("done_pulse", 32'(dn), 32'd0);
    endtask

    initial begin
        logic       bsy, dn, z;
        logic [7:0] q, r;
        int         lat;

        // Reset state
        #12;
        sample(1, bsy, dn, z, q, r);
        chk("rst1_busy", 32'(bsy), 0); chk("rst1_done", 32'(dn), 0);
        chk("rst1_q", 32'(q), 0);      chk("rst1_r", 32'(r), 0);
        sample(2, bsy, dn, z, q, r);
        chk("rst2_dz", 32'(z), 0);     chk("rst2_q", 32'(q), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed 4-bit cases
        run_div(1, 13, 3);
        run_div(1, 15, 1);
        run_div(1, 5, 9);
        run_div(1, 15, 15);
        run_div(1, 0, 7);
        run_div(1, 7, 0);
        run_div(1, 6, 3);

        // Directed 8-bit cases
        run_div(2, 200, 7);
        run_div(2, 255, 16);
        run_div(2, 9, 0);

        // Exhaustive sweep of the 4-bit instance
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(1, 8'(a), 8'(b));
            end
        end

        // Random operands on the 8-bit instance
        for (int i = 0; i < 40; i++) begin
            run_div(2, 8'($urandom), (i % 10 == 0) ? 8'd0 : 8'($urandom));
        end

        // A start pulsed mid-RUN with other operands must be ignored
        @(negedge clk);
        drive(1, 1'b1, 13, 3);
        @(negedge clk);
        drive(1, 1'b0, 0, 0);
        @(negedge clk);
        drive(1, 1'b1, 2, 0);
        @(negedge clk);
        drive(1, 1'b0, 0, 0);
        wait_done(1, lat);
        sample(1, bsy, dn, z, q, r);
        $display("[TB] mid-run start ignored: q=%0d r=%0d dz=%0d", q, r, z);
        chk("ign_done", 32'(dn), 1);
        chk("ign_q", 32'(q), 4);
        chk("ign_r", 32'(r), 1);
        chk("ign_dz", 32'(z), 0);

        // A start held high gives back-to-back divisions
        @(negedge clk);
        drive(1, 1'b1, 14, 4);
        @(posedge clk); #1;
        wait_done(1, lat);
        sample(1, bsy, dn, z, q, r);
        chk("b2b_lat1", 32'(lat), 4);
        chk("b2b_q1", 32'(q), 3);
        chk("b2b_r1", 32'(r), 2);
        drive(1, 1'b1, 11, 5);
        @(posedge clk); #1;
        sample(1, bsy, dn, z, q, r);
        chk("b2b_done_drop", 32'(dn), 0);
        chk("b2b_busy", 32'(bsy), 1);
        chk("b2b_q_held", 32'(q), 3);
        drive(1, 1'b0, 0, 0);
        wait_done(1, lat);
        sample(1, bsy, dn, z, q, r);
        $display("[TB] back-to-back second result: q=%0d r=%0d lat=%0d", q, r, lat);
        chk("b2b_lat2", 32'(lat), 4);
        chk("b2b_q2", 32'(q), 2);
        chk("b2b_r2", 32'(r), 1);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        drive(1, 1'b1, 13, 3);
        @(posedge clk); #1;
        drive(1, 1'b0, 0, 0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        sample(1, bsy, dn, z, q, r);
        $display("[TB] async reset mid-run: busy=%0d done=%0d q=%0d r=%0d", bsy, dn, q, r);
        chk("arst_busy", 32'(bsy), 0);
        chk("arst_done", 32'(dn), 0);
        chk("arst_q", 32'(q), 0);
        chk("arst_r", 32'(r), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_div(1, 9, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lab2_bls_div_ctrl.md
# lab2_bls_div_ctrl

Sequential restoring-division controller built around the team's 4-bit borrow-lookahead subtractor (Lab2_4_bit_BLS_dataflow). It accepts an unsigned dividend/divisor pair on a start pulse and iterates one quotient bit per clock, MSB first, reusing a single combinational subtractor chain for every trial subtraction. It returns quotient, remainder, done and divide-by-zero flags. It sits between the lab's operand registers and the display/result logic, and is the only block driving the subtractor.

## Interface
- N_NIB, 1, number of 4-bit subtractor instances chained by borrow; operand width W = 4*N_NIB (1..4 supported)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- dividend  input  W  unsigned dividend, captured on accepted start
- divisor  input  W  unsigned divisor, captured on accepted start
- busy  output  1  high while a division is in progress (RUN or DZ)
- done  output  1  one-cycle pulse: quotient/remainder/dz are valid
- dz  output  1  divide-by-zero flag for the last result; held until next accepted start
- quotient  output  W  result quotient; held until next accepted start
- remainder  output  W  result remainder; held until next accepted start

## Operation
- States: IDLE, RUN, DZ, DONE. Reset -> IDLE; all outputs, registers and counter = 0.
- IDLE/DONE and start=1: capture Q<=dividend, Dv<=divisor, R<=0, cnt<=W-1, dz<=0. Divisor==0 -> DZ, otherwise -> RUN. start=0: DONE -> IDLE, IDLE stays.
- RUN, each cycle:
  - trial = {R[W-2:0], Q[W-1]}.
  - Subtractor chain computes diff = trial - Dv with bin=0 into the least-significant nibble. Each nibble's bout feeds the next nibble's bin. bout is the last nibble's borrow.
  - qbit = R[W-1] | ~bout. The shifted-out MSB forces success: the true value is < 2*Dv and the mod-2^W diff is exact.
  - R <= qbit ? diff : trial; Q <= {Q[W-2:0], qbit}; cnt <= cnt-1.
  - cnt==0 -> DONE.
- DZ: quotient <= all ones, remainder <= captured dividend, dz <= 1 -> DONE.
- Entering DONE from RUN: quotient <= Q final, remainder <= R final.
- DONE: done=1 for exactly this cycle; busy=0.
- start while busy (RUN/DZ) is ignored with no side effects. Operand inputs are don't-care except at the accepting edge.
- Invariants on every result with divisor != 0: quotient*divisor + remainder == dividend and remainder < divisor.

## Timing
- Accepting edge = E0. busy=1 from E0 until the edge that enters DONE.
- Nonzero divisor: W iterations on edges E0+1..E0+W. DONE is entered at E0+W, so done is high in the cycle after E0+W. Latency is W cycles from the accepting edge to done visible.
- Zero divisor: DONE is entered at E0+1, so done is high one cycle after the accept.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge, giving a new E0. No idle cycle is required, and done does not stay high.
- Result outputs change only on the edge entering DONE or on reset. They do not change at start acceptance, except dz, which clears at acceptance.
- The subtractor path is combinational within one cycle: critical path = N_NIB nibble borrow ripple + qbit mux.
- rst_n low at any time, including mid-RUN: asynchronous clear to IDLE and all outputs 0. The first start after release is accepted normally.

## Test plan
- N_NIB=1, dividend=13, divisor=3, 1-cycle start -> busy 4 cycles, done pulse 4 cycles after accept, quotient=4, remainder=1, dz=0.
- N_NIB=1, pairs 15/1 -> 15 r0; 5/9 -> 0 r5; 15/15 -> 1 r0; 0/7 -> 0 r0. Also an exhaustive 16x15 sweep checking the invariants.
- N_NIB=1, dividend=7, divisor=0 -> done 1 cycle after accept, quotient=15, remainder=7, dz=1. The next valid start clears dz at its accept.
- N_NIB=2, dividend=200, divisor=7 -> done 8 cycles after accept, quotient=28, remainder=4. Also 255/16 -> 15 r15.
- Start pulsed mid-RUN with different operands -> ignored, original result delivered. A start held high through DONE -> new division accepted back-to-back, with a single-cycle done per result.
- rst_n pulsed low 2 cycles into a 13/3 run -> busy, done, quotient and remainder read 0 asynchronously. A following 9/2 returns 4 r1.
